// File: rtl/mmio_timer_cmp.sv
// Memory-mapped free-running timer: prescaler, N compare channels, auto-reload on
// compare 0, overflow flag and a registered level interrupt.
module mmio_timer_cmp #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          CNT_W     = 64,
  parameter int          N_CMP     = 2,
  parameter int          PRESC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic [31:0]      addr,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [CNT_W-1:0] cnt,
  output logic             irq
);

  localparam int HI_W = CNT_W - 32;

  localparam logic [31:0] A_CTRL   = BASE_ADDR + 32'h00;
  localparam logic [31:0] A_CNT_LO = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_CNT_HI = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_PRESC  = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE_ADDR + 32'h10;
  localparam logic [31:0] A_IRQ_EN = BASE_ADDR + 32'h14;
  localparam logic [31:0] A_CMP    = BASE_ADDR + 32'h20;

  // Implemented STATUS / IRQ_EN bits: one MATCH per channel plus OVF in bit 31.
  localparam logic [31:0] STAT_MASK = 32'h8000_0000 | ((32'd1 << N_CMP) - 32'd1);

  logic [1:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        status_q, status_d;
  logic [31:0]        irq_en_q, irq_en_d;
  logic               irq_q;

  logic               wr_ctrl, wr_cnt_lo, wr_cnt_hi, wr_presc, wr_status, wr_irq_en;
  logic               run, tick, tick_eff, wrap, autoclr_hit;
  logic [CNT_W-1:0]   cnt_nxt, cnt_tick;
  logic [N_CMP-1:0]   match_set;
  logic [31:0]        set_vec;
  logic [CNT_W-1:0]   cmp_val [N_CMP];

  assign wr_ctrl   = wr_en && (addr == A_CTRL);
  assign wr_cnt_lo = wr_en && (addr == A_CNT_LO);
  assign wr_cnt_hi = wr_en && (addr == A_CNT_HI);
  assign wr_presc  = wr_en && (addr == A_PRESC);
  assign wr_status = wr_en && (addr == A_STATUS);
  assign wr_irq_en = wr_en && (addr == A_IRQ_EN);

  assign run  = ctrl_q[0] & cnt_en;
  assign tick = run && (pcnt_q == presc_q);

  // A software write to the count consumes the tick: no increment and no flags.
  assign tick_eff    = tick & ~(wr_cnt_lo | wr_cnt_hi);
  assign cnt_nxt     = cnt_q + 1'b1;
  assign wrap        = &cnt_q;
  assign autoclr_hit = ctrl_q[1] && (cnt_nxt == cmp_val[0]);
  assign cnt_tick    = autoclr_hit ? '0 : cnt_nxt;

  generate
    for (genvar gi = 0; gi < N_CMP; gi++) begin : g_cmp
      localparam logic [31:0] A_LO = A_CMP + 32'(8 * gi);
      localparam logic [31:0] A_HI = A_LO + 32'd4;

      logic [CNT_W-1:0] cmp_q, cmp_d;

      always_comb begin
        cmp_d = cmp_q;
        if (wr_en && (addr == A_LO)) cmp_d[31:0]       = wdata;
        if (wr_en && (addr == A_HI)) cmp_d[CNT_W-1:32] = wdata[HI_W-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmp_q <= '1;
        else        cmp_q <= cmp_d;
      end

      assign cmp_val[gi] = cmp_q;

      if (gi == 0) begin : g_reload
        assign match_set[gi] = tick_eff & (autoclr_hit | (cnt_tick == cmp_q));
      end else begin : g_plain
        assign match_set[gi] = tick_eff & (cnt_tick == cmp_q);
      end
    end
  endgenerate

  always_comb begin
    set_vec              = '0;
    set_vec[N_CMP-1:0]   = match_set;
    set_vec[31]          = tick_eff & wrap;
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    irq_en_d = irq_en_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;

    if (wr_ctrl)   ctrl_d   = wdata[1:0];
    if (wr_presc)  presc_d  = wdata[PRESC_W-1:0];
    if (wr_irq_en) irq_en_d = wdata & STAT_MASK;

    if (run) pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    if (wr_presc || wr_cnt_lo || wr_cnt_hi) pcnt_d = '0;

    // Each word write touches only its own half; the other half holds.
    if (wr_cnt_lo || wr_cnt_hi) begin
      if (wr_cnt_lo) cnt_d[31:0]       = wdata;
      if (wr_cnt_hi) cnt_d[CNT_W-1:32] = wdata[HI_W-1:0];
    end else if (tick_eff) begin
      cnt_d = cnt_tick;
    end

    // A set event in the same cycle as its W1C wins.
    status_d = status_q;
    if (wr_status) status_d = status_q & ~(wdata & STAT_MASK);
    status_d = status_d | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      cnt_q    <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      irq_q    <= |(status_q & irq_en_q);
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == A_CTRL)   rdata = {30'd0, ctrl_q};
    if (addr == A_CNT_LO) rdata = cnt_q[31:0];
    if (addr == A_CNT_HI) rdata = 32'(cnt_q[CNT_W-1:32]);
    if (addr == A_PRESC)  rdata = 32'(presc_q);
    if (addr == A_STATUS) rdata = status_q;
    if (addr == A_IRQ_EN) rdata = irq_en_q;
    for (int i = 0; i < N_CMP; i++) begin
      if (addr == A_CMP + 32'(8 * i))     rdata = cmp_val[i][31:0];
      if (addr == A_CMP + 32'(8 * i + 4)) rdata = 32'(cmp_val[i][CNT_W-1:32]);
    end
  end

  assign cnt = cnt_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_timer_cmp.sv
// Directed bench for mmio_timer_cmp: stimulus pushes expected values into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_mmio_timer_cmp;

  localparam logic [31:0] B        = 32'h2000_0000;
  localparam logic [31:0] A_CTRL   = B + 32'h00;
  localparam logic [31:0] A_CNT_LO = B + 32'h04;
  localparam logic [31:0] A_CNT_HI = B + 32'h08;
  localparam logic [31:0] A_PRESC  = B + 32'h0C;
  localparam logic [31:0] A_STATUS = B + 32'h10;
  localparam logic [31:0] A_IRQ_EN = B + 32'h14;
  localparam logic [31:0] A_CMPL0  = B + 32'h20;
  localparam logic [31:0] A_CMPH0  = B + 32'h24;
  localparam logic [31:0] A_CMPL1  = B + 32'h28;
  localparam logic [31:0] A_CMPH1  = B + 32'h2C;
  localparam logic [31:0] A_IDLE   = 32'h1000_0000;

  localparam int K_RD  = 0;
  localparam int K_CNT = 1;
  localparam int K_IRQ = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_en;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [63:0] cnt;
  logic        irq;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   pending = 0;
  int   total   = 0;
  int   bad     = 0;

  mmio_timer_cmp #(
    .BASE_ADDR(32'h2000_0000),
    .CNT_W    (64),
    .N_CMP    (2),
    .PRESC_W  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_en(cnt_en),
    .addr  (addr),
    .wr_en (wr_en),
    .wdata (wdata),
    .rdata (rdata),
    .cnt   (cnt),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < pending; i++) begin
      chk_t        it;
      logic [63:0] act;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow got=empty required=item");
      end else begin
        it = sb_q.pop_front();
        case (it.kind)
          K_RD:    act = {32'd0, rdata};
          K_CNT:   act = cnt;
          default: act = {63'd0, irq};
        endcase
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s got=%h required=%h", it.name, act, it.exp);
        end else begin
          $display("txn %s got=%h ok", it.name, act);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [63:0] v, input string name);
    chk_t it;
    it.kind = kind;
    it.exp  = v;
    it.name = name;
    sb_q.push_back(it);
    pending++;
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [31:0] v, input string name);
    addr = a;
    push(K_RD, {32'd0, v}, name);
  endtask

  task automatic exp_cnt(input logic [63:0] v, input string name);
    push(K_CNT, v, name);
  endtask

  task automatic exp_irq(input logic v, input string name);
    push(K_IRQ, {63'd0, v}, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pending = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    addr  = A_IDLE;
  endtask

  initial begin
    logic [63:0] seq3 [8];
    seq3 = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd1, 64'd2};

    rst_n  = 1'b0;
    cnt_en = 1'b0;
    addr   = A_IDLE;
    wr_en  = 1'b0;
    wdata  = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset values
    exp_rd(A_CTRL, 32'h0, "rst_ctrl"); exp_cnt(64'd0, "rst_cnt"); exp_irq(1'b0, "rst_irq"); step();
    exp_rd(A_CMPL0, 32'hFFFF_FFFF, "rst_cmp_lo0"); step();
    exp_rd(A_CMPH1, 32'hFFFF_FFFF, "rst_cmp_hi1"); step();

    // Free-run with PRESC=0, then gate off
    cnt_en = 1'b1;
    wr(A_CTRL, 32'h1);
    repeat (10) step();
    cnt_en = 1'b0;
    exp_cnt(64'd10, "run10_cnt"); exp_rd(A_CNT_LO, 32'd10, "run10_lo"); step();
    repeat (5) step();
    exp_cnt(64'd10, "gated_cnt"); step();
    wr(A_CTRL, 32'h0);

    // Prescaler 3: one tick per 4 cycles, PRESC write restarts the period
    wr(A_PRESC, 32'd3);
    wr(A_CNT_LO, 32'd0);
    wr(A_CTRL, 32'h1);
    cnt_en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_cnt(64'(k / 4), $sformatf("presc_k%0d", k));
      step();
    end
    wr(A_PRESC, 32'd3);
    for (int j = 0; j < 5; j++) begin
      exp_cnt((j == 4) ? 64'd3 : 64'd2, $sformatf("presc_restart_j%0d", j));
      step();
    end
    cnt_en = 1'b0;
    wr(A_CTRL, 32'h0);
    wr(A_PRESC, 32'd0);

    // Auto-reload on CMP_0=5 with interrupt
    wr(A_CMPL0, 32'd5);
    wr(A_CMPH0, 32'd0);
    wr(A_IRQ_EN, 32'h1);
    wr(A_CNT_LO, 32'd0);
    wr(A_CTRL, 32'h3);
    cnt_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_cnt(seq3[k], $sformatf("reload_cnt_k%0d", k));
      exp_irq(k >= 6, $sformatf("reload_irq_k%0d", k));
      exp_rd(A_STATUS, (k >= 5) ? 32'h1 : 32'h0, $sformatf("reload_stat_k%0d", k));
      step();
    end
    cnt_en = 1'b0;
    wr(A_STATUS, 32'h1);
    exp_rd(A_STATUS, 32'h0, "w1c_stat"); exp_irq(1'b1, "w1c_irq_lag"); step();
    exp_irq(1'b0, "w1c_irq_clr"); step();
    wr(A_CTRL, 32'h0);
    wr(A_IRQ_EN, 32'h0);
    wr(A_CMPL0, 32'hFFFF_FFFF);
    wr(A_CMPH0, 32'hFFFF_FFFF);

    // Wrap to 0 with a concurrent W1C of OVF
    wr(A_CNT_LO, 32'hFFFF_FFFF);
    wr(A_CNT_HI, 32'hFFFF_FFFF);
    exp_cnt(64'hFFFF_FFFF_FFFF_FFFF, "max_cnt"); exp_rd(A_CNT_HI, 32'hFFFF_FFFF, "max_hi"); step();
    wr(A_CTRL, 32'h1);
    cnt_en = 1'b1;
    wr(A_STATUS, 32'h8000_0000);
    cnt_en = 1'b0;
    exp_cnt(64'd0, "wrap_cnt"); exp_rd(A_STATUS, 32'h8000_0000, "wrap_ovf_wins"); step();
    wr(A_STATUS, 32'h0);
    exp_rd(A_STATUS, 32'h8000_0000, "w1c_zero_noop"); step();
    wr(A_STATUS, 32'h8000_0000);
    exp_rd(A_STATUS, 32'h0, "ovf_cleared"); step();

    // SW write on a tick cycle beats the increment and never sets MATCH
    wr(A_CNT_HI, 32'd2);
    wr(A_CMPL1, 32'd7);
    wr(A_CMPH1, 32'd2);
    cnt_en = 1'b1;
    wr(A_CNT_LO, 32'd7);
    cnt_en = 1'b0;
    exp_cnt(64'h2_0000_0007, "sw_wr_cnt"); exp_rd(A_STATUS, 32'h0, "sw_wr_nomatch"); step();
    wr(A_CNT_LO, 32'd6);
    cnt_en = 1'b1;
    step();
    cnt_en = 1'b0;
    exp_cnt(64'h2_0000_0007, "tick_cnt"); exp_rd(A_STATUS, 32'h2, "tick_match1"); step();

    // Reset mid-prescale
    wr(A_PRESC, 32'd2);
    wr(A_IRQ_EN, 32'h2);
    step();
    exp_irq(1'b1, "irq_en_irq"); step();
    cnt_en = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    exp_cnt(64'd0, "in_rst_cnt"); exp_irq(1'b0, "in_rst_irq"); step();
    rst_n = 1'b1;
    exp_rd(A_CTRL, 32'h0, "post_rst_ctrl"); exp_cnt(64'd0, "post_rst_cnt"); step();
    exp_rd(A_PRESC, 32'h0, "post_rst_presc"); exp_irq(1'b0, "post_rst_irq"); step();
    exp_rd(A_STATUS, 32'h0, "post_rst_stat"); step();
    exp_rd(A_CMPH1, 32'hFFFF_FFFF, "post_rst_cmp_hi1"); step();
    exp_rd(A_CMPL1, 32'hFFFF_FFFF, "post_rst_cmp_lo1"); step();
    exp_rd(B + 32'h18, 32'h0, "unmapped_18"); step();
    exp_rd(B + 32'h21, 32'h0, "unaligned_21"); step();
    cnt_en = 1'b0;
    wr(B + 32'h18, 32'h3);
    exp_rd(A_CTRL, 32'h0, "unmapped_wr_ignored"); step();
    wr(A_IRQ_EN, 32'hFFFF_FFFF);
    exp_rd(A_IRQ_EN, 32'h8000_0003, "irq_en_mask"); step();
    step();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
